// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types, defaults and round-constant helper for the Ascon permutation engine
// Contents: type_state (five 64-bit words, index 0 = x0), default final round index,
//           FSM state enum, round_const() for the constant-addition layer.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int ROUND_MAX_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_fsm;

    // High nibble counts down while the low nibble counts up: r=0 -> 0xF0, r=11 -> 0x4B.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/ascon_sbox_layer.sv
// rtl/ascon_sbox_layer.sv - combinational Ascon 5-bit S-box applied to all 64 bit-columns
// Ports: state  - input permutation state
//        result - state after the substitution layer
module ascon_sbox_layer
    import ascon_pack::*;
(
    input  type_state state,
    output type_state result
);

    // Bit-sliced form: each 64-bit operation processes all columns at once,
    // column i = {x0[i], x1[i], x2[i], x3[i], x4[i]}.
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;

    always_comb begin
        a0 = state[0] ^ state[4];
        a1 = state[1];
        a2 = state[2] ^ state[1];
        a3 = state[3];
        a4 = state[4] ^ state[3];

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;

        result[1] = b1 ^ b0;
        result[0] = b0 ^ b4;
        result[3] = b3 ^ b2;
        result[2] = ~b2;
        result[4] = b4;
    end

endmodule

// File: rtl/pl_diffusion.sv
// rtl/pl_diffusion.sv - combinational Ascon linear diffusion layer
// Ports: state  - input permutation state
//        result - each word XORed with two right-rotations of itself
module pl_diffusion
    import ascon_pack::*;
(
    input  type_state state,
    output type_state result
);

    function automatic logic [63:0] mix(input logic [63:0] x, input int n1, input int n2);
        logic [63:0] r1;
        logic [63:0] r2;
        r1 = (x >> n1) | (x << (64 - n1));
        r2 = (x >> n2) | (x << (64 - n2));
        return x ^ r1 ^ r2;
    endfunction

    assign result[0] = mix(state[0], 19, 28);
    assign result[1] = mix(state[1], 61, 39);
    assign result[2] = mix(state[2],  1,  6);
    assign result[3] = mix(state[3], 10, 17);
    assign result[4] = mix(state[4],  7, 41);

endmodule

// File: rtl/perm_round_engine.sv
// rtl/perm_round_engine.sv - iterative Ascon permutation, one full round per clock
// Ports: clock_i       - clock, rising edge
//        resetb_i      - asynchronous active-low reset
//        start_i       - run request, accepted in IDLE or DONE when round_start_i <= ROUND_MAX
//        round_start_i - first round index (0 = p12, 4 = p8, 6 = p6)
//        state_i       - permutation input, sampled on an accepted start
//        state_o       - state register
//        busy_o        - high while rounds execute
//        done_o        - one-cycle pulse, state_o holds the result
module perm_round_engine
    import ascon_pack::*;
#(
    parameter int ROUND_MAX = ROUND_MAX_DEFAULT
)(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [3:0] round_start_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] RMAX = ROUND_MAX[3:0];

    type_fsm    fsm;
    logic [3:0] rnd;
    type_state  cadd;
    type_state  sout;
    type_state  lout;

    // Constant addition touches only the low byte of x2.
    always_comb begin
        cadd       = state_o;
        cadd[2][7:0] = state_o[2][7:0] ^ round_const(rnd);
    end

    ascon_sbox_layer u_sbox (
        .state  (cadd),
        .result (sout)
    );

    pl_diffusion u_diff (
        .state  (sout),
        .result (lout)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            rnd     <= 4'd0;
            state_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (start_i && (round_start_i <= RMAX)) begin
                        state_o <= state_i;
                        rnd     <= round_start_i;
                        fsm     <= RUN;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                    end else begin
                        fsm     <= IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b0;
                    end
                end
                RUN: begin
                    state_o <= lout;
                    if (rnd == RMAX) begin
                        // Counter stays at the final index rather than stepping past it.
                        fsm    <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        rnd    <= rnd + 4'd1;
                    end
                end
                default: begin
                    fsm    <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/perm_round_engine.md
PERM_ROUND_ENGINE -- requirements
Module: perm_round_engine

Interface
REQ-001 Parameter: ROUND_MAX, default 11, index of the final Ascon round.
REQ-002 clock_i  input  1  sole clock; all state updates on rising edge.
REQ-003 resetb_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to run a permutation on state_i.
REQ-005 round_start_i  input  4  first round index: 0 for p12, 4 for p8, 6 for p6.
REQ-006 state_i  input  type_state (5x64)  permutation input, sampled only on an accepted start.
REQ-007 state_o  output  type_state (5x64)  permutation state register, driven directly.
REQ-008 busy_o  output  1  high while rounds are executing.
REQ-009 done_o  output  1  one-cycle pulse; state_o holds the final result.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 A start SHALL be accepted only in IDLE or DONE, with start_i=1 and round_start_i<=ROUND_MAX.
REQ-012 Accept action: load state_i into the state register, load round_start_i into the round counter, enter RUN.
REQ-013 Accept rules:
- start_i in RUN SHALL be ignored.
- start_i with round_start_i>ROUND_MAX SHALL be ignored; FSM stays in IDLE or moves DONE->IDLE.
REQ-014 Each RUN cycle SHALL update state <= L(S(C(state, r))), where r is the round counter, then increment r.
REQ-015 C SHALL XOR constant ((15-r)<<4)|r into bits [7:0] of word x2; r=0 gives 0xF0, r=11 gives 0x4B.
REQ-016 S SHALL be the existing 64-column Ascon 5-bit S-box layer, column i = {x0[i],x1[i],x2[i],x3[i],x4[i]}.
REQ-017 L SHALL XOR each word with two right-rotations of itself:
- x0: 19, 28
- x1: 61, 39
- x2: 1, 6
- x3: 10, 17
- x4: 7, 41
REQ-018 When the round computed in a RUN cycle uses r=ROUND_MAX, the FSM SHALL go to DONE on that edge.
REQ-019 The round counter SHALL be 4 bits and SHALL never be used beyond ROUND_MAX (no wrap-around).
REQ-020 Latency: with start accepted at edge k, rounds occur at edges k+1..k+N, where N=ROUND_MAX+1-round_start_i.
REQ-021 done_o SHALL be high exactly during the cycle following edge k+N.
REQ-022 busy_o SHALL be 1 in RUN only; done_o SHALL be 1 in DONE only; both SHALL never be high together.
REQ-023 DONE SHALL last one cycle and then go to IDLE, unless a start is accepted (back-to-back restart).
REQ-024 state_o SHALL hold the final result unchanged in IDLE until the next accepted start.

Reset
REQ-025 resetb_i low SHALL asynchronously force:
- FSM to IDLE
- round counter to 0
- state register to all-zero
- busy_o=0, done_o=0
REQ-026 Reset asserted during RUN SHALL abort the permutation with no done_o pulse.
REQ-027 After reset release, the first rising edge SHALL behave as an IDLE cycle.

Structure
REQ-028 ascon_pack SHALL hold:
- type_state
- the ROUND_MAX default value
- the FSM state enum
- the round-constant function
REQ-029 The linear layer SHALL be a combinational sub-module named pl_diffusion (type_state in/out).
REQ-030 The S-box layer SHALL be instantiated unchanged; constant addition SHALL be inline.
REQ-031 Each round (C, S, L) SHALL be one combinational cycle, with no internal pipelining.

Verification
REQ-032 p12 from reset: state_i=all-zero, round_start_i=0, start 1 cycle -> busy_o high 12 cycles, then done_o 1 cycle; state_o equals software model.
REQ-033 p6: round_start_i=6, random state_i -> busy_o high 6 cycles, done_o on cycle 7 after accept; state_o equals model; first constant 0x96.
REQ-034 Ignored starts:
- start_i pulsed at RUN cycle 3 -> no effect; result identical to undisturbed run.
- round_start_i=12 -> FSM stays IDLE, state_o unchanged.
REQ-035 Back-to-back: start_i held high through done_o -> second run accepted in DONE cycle with no idle gap; both results equal model.
REQ-036 Reset mid-run: resetb_i low at RUN cycle 5 -> state_o=0, busy_o=0 immediately; no done_o pulse; a new p12 after release completes normally.
REQ-037 Single round: round_start_i=11, state_i=all-zero -> one RUN cycle with constant 0x4B, done_o next cycle; state_o equals model.
